// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, register-index helpers and the
// execute-control bundle layout produced by the decoder.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CTRL_W     = 16;
    localparam int unsigned CNT_W      = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } opa_sel_e;

    // Layout of the CTRL_W-bit bundle; this stage treats it as opaque.
    typedef struct packed {
        alu_op_e   alu_op;
        opa_sel_e  opa_sel;
        logic      opb_imm;
        logic      mem_rd;
        logic      mem_wr;
        logic [2:0] mem_size;
        logic      reg_wr;
        logic      branch;
        logic      jump;
        logic      rsvd;
    } ex_ctrl_t;

    // True when an enabled writer targets the given non-zero index.
    function automatic logic writer_hit(input logic en, input reg_addr_t rd, input reg_addr_t idx);
        return en && (rd == idx) && (idx != ZERO_REG);
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Selects one source operand from the EX/MEM/WB writers or the register file,
// youngest writer first.
module operand_bypass
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic [REG_ADDR_W-1:0] idx_i,
    input  logic                  ex_wr_en_i,
    input  logic                  ex_is_load_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [XLEN-1:0]       ex_result_i,
    input  logic                  mem_wr_en_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic [XLEN-1:0]       mem_result_i,
    input  logic                  wb_wr_en_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]       wb_data_i,
    input  logic [XLEN-1:0]       rf_data_i,
    output logic [XLEN-1:0]       operand_c
);

    // A load in EX has no data yet; it is covered by the hazard stall instead.
    always_comb begin
        operand_c = rf_data_i;
        if (idx_i == ZERO_REG) begin
            operand_c = '0;
        end else if (writer_hit(ex_wr_en_i && !ex_is_load_i, ex_rd_i, idx_i)) begin
            operand_c = ex_result_i;
        end else if (writer_hit(mem_wr_en_i, mem_rd_i, idx_i)) begin
            operand_c = mem_result_i;
        end else if (writer_hit(wb_wr_en_i, wb_rd_i, idx_i)) begin
            operand_c = wb_data_i;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: register-file addressing, operand bypassing,
// load-use stall and the ID/EX pipeline register.
module operand_fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = riscv_pkg::XLEN,
    parameter int unsigned CTRL_W = riscv_pkg::CTRL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_uses_rs1,
    input  logic                  in_uses_rs2,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic                  in_is_load,
    output logic [REG_ADDR_W-1:0] rf_rs1,
    output logic [REG_ADDR_W-1:0] rf_rs2,
    input  logic [XLEN-1:0]       rf_data1,
    input  logic [XLEN-1:0]       rf_data2,
    input  logic                  ex_wr_en,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_result,
    input  logic                  mem_wr_en,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_result,
    input  logic                  wb_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_imm,
    output logic [XLEN-1:0]       out_rs1_val,
    output logic [XLEN-1:0]       out_rs2_val,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic                  out_is_load,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic [XLEN-1:0]       rs1_val_c, rs2_val_c;
    logic                  hazard_c, advance_c, bubble_c;

    logic                  valid_q,   valid_d;
    logic [XLEN-1:0]       pc_q,      pc_d;
    logic [XLEN-1:0]       imm_q,     imm_d;
    logic [XLEN-1:0]       rs1_val_q, rs1_val_d;
    logic [XLEN-1:0]       rs2_val_q, rs2_val_d;
    logic [REG_ADDR_W-1:0] rd_q,      rd_d;
    logic [CTRL_W-1:0]     ctrl_q,    ctrl_d;
    logic                  is_load_q, is_load_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;

    assign rf_rs1 = in_rs1;
    assign rf_rs2 = in_rs2;

    operand_bypass #(.XLEN(XLEN)) u_bypass_rs1 (
        .idx_i        (in_rs1),
        .ex_wr_en_i   (ex_wr_en),
        .ex_is_load_i (ex_is_load),
        .ex_rd_i      (ex_rd),
        .ex_result_i  (ex_result),
        .mem_wr_en_i  (mem_wr_en),
        .mem_rd_i     (mem_rd),
        .mem_result_i (mem_result),
        .wb_wr_en_i   (wb_wr_en),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .rf_data_i    (rf_data1),
        .operand_c    (rs1_val_c)
    );

    operand_bypass #(.XLEN(XLEN)) u_bypass_rs2 (
        .idx_i        (in_rs2),
        .ex_wr_en_i   (ex_wr_en),
        .ex_is_load_i (ex_is_load),
        .ex_rd_i      (ex_rd),
        .ex_result_i  (ex_result),
        .mem_wr_en_i  (mem_wr_en),
        .mem_rd_i     (mem_rd),
        .mem_result_i (mem_result),
        .wb_wr_en_i   (wb_wr_en),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .rf_data_i    (rf_data2),
        .operand_c    (rs2_val_c)
    );

    // Load-use: only sources the instruction actually reads can stall it.
    always_comb begin
        hazard_c  = ex_wr_en && ex_is_load && (ex_rd != ZERO_REG) &&
                    ((in_uses_rs1 && (in_rs1 == ex_rd)) ||
                     (in_uses_rs2 && (in_rs2 == ex_rd)));
        advance_c = out_ready || !valid_q;
        in_ready  = advance_c && !hazard_c && !flush;
        bubble_c  = in_valid && hazard_c && advance_c && !flush;
    end

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        rd_d      = rd_q;
        ctrl_d    = ctrl_q;
        is_load_d = is_load_q;
        cnt_d     = cnt_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (advance_c) begin
            valid_d = in_valid && !hazard_c;
            if (in_valid && !hazard_c) begin
                pc_d      = in_pc;
                imm_d     = in_imm;
                rs1_val_d = rs1_val_c;
                rs2_val_d = rs2_val_c;
                rd_d      = in_rd;
                ctrl_d    = in_ctrl;
                is_load_d = in_is_load;
            end
        end

        if (bubble_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ID/EX register; reset drops any held instruction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
            is_load_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
            is_load_q <= is_load_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_imm     = imm_q;
    assign out_rs1_val = rs1_val_q;
    assign out_rs2_val = rs2_val_q;
    assign out_rd      = rd_q;
    assign out_ctrl    = ctrl_q;
    assign out_is_load = is_load_q;
    assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vector table, hand-written corner
// sequences, then random traffic against a behavioural model.
module tb_operand_fetch_stage;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [XLEN-1:0]   in_pc, in_imm;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic              in_uses_rs1, in_uses_rs2;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_is_load;
    logic [4:0]        rf_rs1, rf_rs2;
    logic [XLEN-1:0]   rf_data1, rf_data2;
    logic              ex_wr_en, ex_is_load;
    logic [4:0]        ex_rd;
    logic [XLEN-1:0]   ex_result;
    logic              mem_wr_en;
    logic [4:0]        mem_rd;
    logic [XLEN-1:0]   mem_result;
    logic              wb_wr_en;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              out_valid, out_ready;
    logic [XLEN-1:0]   out_pc, out_imm, out_rs1_val, out_rs2_val;
    logic [4:0]        out_rd;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_is_load;
    logic [31:0]       bubble_cnt;

    operand_fetch_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_imm(in_imm), .in_ctrl(in_ctrl), .in_is_load(in_is_load),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_ctrl(out_ctrl), .out_is_load(out_is_load),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_ctrl = '0; in_is_load = 1'b0;
        rf_data1 = '0; rf_data2 = '0;
        ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_result = '0;
        mem_wr_en = 1'b0; mem_rd = '0; mem_result = '0;
        wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    // Reference operand: walk writers youngest-first, fall back to the register file.
    function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rf);
        logic        en [3];
        logic [4:0]  rd [3];
        logic [31:0] val[3];
        en[0] = ex_wr_en && !ex_is_load; rd[0] = ex_rd;  val[0] = ex_result;
        en[1] = mem_wr_en;               rd[1] = mem_rd; val[1] = mem_result;
        en[2] = wb_wr_en;                rd[2] = wb_rd;  val[2] = wb_data;
        if (idx == 5'd0) return 32'd0;
        for (int k = 0; k < 3; k++) begin
            if (en[k] && rd[k] == idx) return val[k];
        end
        return rf;
    endfunction

    typedef struct {
        logic        ex_wr, ex_ld;  logic [4:0] ex_rd_v;  logic [31:0] ex_res;
        logic        mem_wr;        logic [4:0] mem_rd_v; logic [31:0] mem_res;
        logic        wb_wr;         logic [4:0] wb_rd_v;  logic [31:0] wb_dat;
        logic [4:0]  rs1, rs2;      logic use1, use2;     logic [31:0] rf1, rf2;
        logic        exp_ready, exp_valid; logic [31:0] exp_v1, exp_v2, exp_cnt;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc, imm, v1, v2;
        logic [4:0]  rd;
        logic [15:0] ctrl;
        logic        ld;
        logic [31:0] cnt;
    } model_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t   tbl[7];
        model_t m, mn;
        logic   haz, adv, exp_rdy;

        tbl[0] = '{1'b0,1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b1,5'd5,32'h1234,
                   5'd5,5'd0,1'b1,1'b0,32'h0,32'h0,   1'b1,1'b1,32'h1234,32'h0,32'd0,1'b1};
        tbl[1] = '{1'b1,1'b0,5'd7,32'hA,  1'b1,5'd7,32'hB,  1'b1,5'd7,32'hC,
                   5'd1,5'd7,1'b1,1'b1,32'h11,32'h0,  1'b1,1'b1,32'h11,32'hA,32'd0,1'b1};
        tbl[2] = '{1'b0,1'b0,5'd7,32'hA,  1'b1,5'd7,32'hB,  1'b1,5'd7,32'hC,
                   5'd7,5'd7,1'b1,1'b1,32'h0,32'h0,   1'b1,1'b1,32'hB,32'hB,32'd0,1'b1};
        tbl[3] = '{1'b1,1'b0,5'd0,32'hFFFF, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,
                   5'd0,5'd0,1'b1,1'b1,32'h0,32'h0,   1'b1,1'b1,32'h0,32'h0,32'd0,1'b1};
        tbl[4] = '{1'b1,1'b1,5'd3,32'h77, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,
                   5'd3,5'd2,1'b0,1'b1,32'h33,32'h22, 1'b1,1'b1,32'h33,32'h22,32'd0,1'b1};
        tbl[5] = '{1'b1,1'b1,5'd3,32'h77, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,
                   5'd3,5'd0,1'b1,1'b0,32'h0,32'h0,   1'b0,1'b0,32'h0,32'h0,32'd1,1'b0};
        tbl[6] = '{1'b0,1'b0,5'd0,32'h0,  1'b1,5'd3,32'h55, 1'b0,5'd0,32'h0,
                   5'd3,5'd0,1'b1,1'b0,32'h0,32'h0,   1'b1,1'b1,32'h55,32'h0,32'd1,1'b1};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_cnt", bubble_cnt, 32'd0);
        rst = 1'b0;

        // Directed vector table, out_ready held high.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_pc = 32'h100 + 32'(4 * i); in_imm = 32'(i) * 32'h11;
            in_rd = 5'(i + 1); in_ctrl = 16'(i + 'hA0); in_is_load = 1'b0;
            ex_wr_en = tbl[i].ex_wr; ex_is_load = tbl[i].ex_ld; ex_rd = tbl[i].ex_rd_v; ex_result = tbl[i].ex_res;
            mem_wr_en = tbl[i].mem_wr; mem_rd = tbl[i].mem_rd_v; mem_result = tbl[i].mem_res;
            wb_wr_en = tbl[i].wb_wr; wb_rd = tbl[i].wb_rd_v; wb_data = tbl[i].wb_dat;
            in_rs1 = tbl[i].rs1; in_rs2 = tbl[i].rs2; in_uses_rs1 = tbl[i].use1; in_uses_rs2 = tbl[i].use2;
            rf_data1 = tbl[i].rf1; rf_data2 = tbl[i].rf2;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ready));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("vec%0d_bubble_cnt", i), bubble_cnt, tbl[i].exp_cnt);
            if (tbl[i].chk_data) begin
                chk($sformatf("vec%0d_rs1_val", i), out_rs1_val, tbl[i].exp_v1);
                chk($sformatf("vec%0d_rs2_val", i), out_rs2_val, tbl[i].exp_v2);
                chk($sformatf("vec%0d_pc", i), out_pc, 32'h100 + 32'(4 * i));
            end
        end

        // Backpressure: held instruction (vector 6) must stay put.
        idle_inputs();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_pc = 32'hDEAD_0000 + 32'(c); in_rs1 = 5'd9; in_uses_rs1 = 1'b1;
            rf_data1 = 32'hBEEF; in_imm = 32'h999; in_rd = 5'd20;
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc", out_pc, 32'h118);
            chk("stall_imm", out_imm, 32'h66);
            chk("stall_rs1_val", out_rs1_val, 32'h55);
            chk("stall_rd", 32'(out_rd), 32'd7);
            chk("stall_ctrl", 32'(out_ctrl), 32'hA6);
        end
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;

        // Mid-stream asynchronous reset.
        out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h200; in_imm = 32'h5; in_rd = 5'd4;
        in_ctrl = 16'h3; in_is_load = 1'b1; rf_data1 = 32'h42;
        @(posedge clk); #1;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_pc", out_pc, 32'd0);
        chk("async_rst_imm", out_imm, 32'd0);
        chk("async_rst_rs1", out_rs1_val, 32'd0);
        chk("async_rst_rs2", out_rs2_val, 32'd0);
        chk("async_rst_rd", 32'(out_rd), 32'd0);
        chk("async_rst_ctrl", 32'(out_ctrl), 32'd0);
        chk("async_rst_load", 32'(out_is_load), 32'd0);
        chk("async_rst_cnt", bubble_cnt, 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Random traffic against the behavioural model.
        m = '{1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0, 32'd0};
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_pc = $urandom; in_imm = $urandom; in_rd = 5'($urandom_range(0, 31));
            in_ctrl = 16'($urandom); in_is_load = 1'($urandom);
            in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
            in_uses_rs1 = 1'($urandom); in_uses_rs2 = 1'($urandom);
            rf_data1 = $urandom; rf_data2 = $urandom;
            ex_wr_en = 1'($urandom); ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd = 5'($urandom_range(0, 7)); ex_result = $urandom;
            mem_wr_en = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
            wb_wr_en = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            haz = ex_wr_en && ex_is_load && ex_rd != 5'd0 &&
                  ((in_uses_rs1 && in_rs1 == ex_rd) || (in_uses_rs2 && in_rs2 == ex_rd));
            adv = out_ready || !m.valid;
            exp_rdy = adv && !haz && !flush;
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("rnd_rf_addr", {22'd0, rf_rs2, rf_rs1}, {22'd0, in_rs2, in_rs1});
            mn = m;
            if (flush) begin
                mn.valid = 1'b0;
            end else if (adv && in_valid && !haz) begin
                mn = '{1'b1, in_pc, in_imm, ref_operand(in_rs1, rf_data1),
                       ref_operand(in_rs2, rf_data2), in_rd, in_ctrl, in_is_load, m.cnt};
            end else if (adv) begin
                mn.valid = 1'b0;
            end
            if (in_valid && haz && adv && !flush && m.cnt != 32'hFFFF_FFFF) mn.cnt = m.cnt + 32'd1;
            @(posedge clk); #1;
            m = mn;
            chk("rnd_valid", 32'(out_valid), 32'(m.valid));
            chk("rnd_pc", out_pc, m.pc);
            chk("rnd_imm", out_imm, m.imm);
            chk("rnd_rs1_val", out_rs1_val, m.v1);
            chk("rnd_rs2_val", out_rs2_val, m.v2);
            chk("rnd_rd_ctrl_ld", {10'd0, out_is_load, out_rd, out_ctrl}, {10'd0, m.ld, m.rd, m.ctrl});
            chk("rnd_bubble_cnt", bubble_cnt, m.cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
